// File: rtl/oh_cell_bist.sv
// oh_cell_bist: built-in self-test sequencer for a 2-input logic cell.
// Sweeps {a,b} through 00,01,10,11 for PASSES sweeps. Each vector is held
// for SETTLE cycles and then compared against TRUTH[{a,b}]. Mismatches are
// counted (saturating) and flagged per vector.
// Optional macro OH_CELL_BIST_SYNC_EN: z goes through a two-flop synchronizer,
// and the hold time is stretched by two cycles to cover the synchronizer delay.
module oh_cell_bist #(
  parameter logic [3:0]  TRUTH  = 4'b0111,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned PASSES = 1,
  parameter int unsigned EW     = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  input  logic          abort,
  input  logic          z,
  output logic          a,
  output logic          b,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [EW-1:0] err_count,
  output logic [3:0]    fail_vec
);

  typedef enum logic [1:0] {IDLE, HOLD, CMP, FIN} state_t;

`ifdef OH_CELL_BIST_SYNC_EN
  localparam int unsigned HOLD_LEN = SETTLE + 2;

  logic z_s1;
  logic z_s2;
  logic z_cmp;

  // Two-flop synchronizer on the cell output.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      z_s1 <= 1'b0;
      z_s2 <= 1'b0;
    end else begin
      z_s1 <= z;
      z_s2 <= z_s1;
    end
  end

  assign z_cmp = z_s2;
`else
  localparam int unsigned HOLD_LEN = SETTLE;

  logic z_cmp;
  assign z_cmp = z;
`endif

  localparam logic [8:0] HOLD_LAST = 9'(HOLD_LEN - 1);
  localparam logic [7:0] PASS_LAST = 8'(PASSES - 1);

  state_t        state, state_n;
  logic [8:0]    hold_cnt, hold_n;
  logic [7:0]    pass_cnt, pass_cnt_n;
  logic [1:0]    vec, vec_n;
  logic [1:0]    ab_n;
  logic          busy_n, done_n, pass_n;
  logic [EW-1:0] err_n, err_upd;
  logic [3:0]    fv_n;

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      pass_cnt  <= '0;
      vec       <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      pass_cnt  <= pass_cnt_n;
      vec       <= vec_n;
      a         <= ab_n[1];
      b         <= ab_n[0];
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      err_count <= err_n;
      fail_vec  <= fv_n;
    end
  end

  // Next-state and next-output logic; abort overrides any compare update.
  always_comb begin
    state_n    = state;
    hold_n     = hold_cnt;
    pass_cnt_n = pass_cnt;
    vec_n      = vec;
    ab_n       = {a, b};
    busy_n     = busy;
    done_n     = 1'b0;
    pass_n     = pass;
    err_n      = err_count;
    fv_n       = fail_vec;
    err_upd    = err_count;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n    = HOLD;
          hold_n     = '0;
          pass_cnt_n = '0;
          vec_n      = '0;
          ab_n       = '0;
          busy_n     = 1'b1;
          pass_n     = 1'b0;
          err_n      = '0;
          fv_n       = '0;
        end
      end

      HOLD: begin
        if (abort) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          ab_n    = '0;
          pass_n  = 1'b0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n = CMP;
          hold_n  = '0;
        end else begin
          hold_n = hold_cnt + 9'd1;
        end
      end

      CMP: begin
        if (abort) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          ab_n    = '0;
          pass_n  = 1'b0;
        end else begin
          if (z_cmp != TRUTH[vec]) begin
            fv_n[vec] = 1'b1;
            if (err_count != '1) err_upd = err_count + 1'b1;
          end
          err_n = err_upd;
          if (vec != 2'd3) begin
            state_n = HOLD;
            vec_n   = vec + 2'd1;
            ab_n    = vec + 2'd1;
          end else if (pass_cnt != PASS_LAST) begin
            state_n    = HOLD;
            vec_n      = '0;
            ab_n       = '0;
            pass_cnt_n = pass_cnt + 8'd1;
          end else begin
            // pass is decided from the count including this final compare.
            state_n = FIN;
            vec_n   = '0;
            ab_n    = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_upd == '0);
          end
        end
      end

      FIN: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oh_cell_bist.sv
// tb_oh_cell_bist: scoreboard bench for oh_cell_bist.
// Three instances: defaults (fault modes selectable), PASSES=3/EW=2, SETTLE=1.
module tb_oh_cell_bist;

`ifdef OH_CELL_BIST_SYNC_EN
  localparam int PAD = 2;
`else
  localparam int PAD = 0;
`endif

  typedef struct packed {
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err;
    logic [3:0] fv;
  } obs_t;

  typedef struct {
    int         lat;
    bit         pass;
    int         err;
    logic [3:0] fv;
  } exp_t;

  logic clk;
  logic nreset;
  logic [2:0] start_v;
  logic [2:0] abort_v;

  logic a0, b0, busy0, done0, pass0, z0;
  logic a1, b1, busy1, done1, pass1, z1;
  logic a2, b2, busy2, done2, pass2, z2;
  logic [7:0] err0, err2;
  logic [1:0] err1;
  logic [3:0] fv0, fv1, fv2;

  // Cell models: 0 = ideal NAND, 1 = stuck at 1, 2 = stuck at 0.
  int mode0, mode1, mode2;
  assign z0 = (mode0 == 0) ? ~(a0 & b0) : (mode0 == 1);
  assign z1 = (mode1 == 0) ? ~(a1 & b1) : (mode1 == 1);
  assign z2 = (mode2 == 0) ? ~(a2 & b2) : (mode2 == 1);

  int n_checks;
  int n_fail;
  exp_t exp_q[$];

  oh_cell_bist #(.TRUTH(4'b0111), .SETTLE(2), .PASSES(1), .EW(8)) u_dut0 (
    .clk(clk), .nreset(nreset), .start(start_v[0]), .abort(abort_v[0]), .z(z0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_vec(fv0));

  oh_cell_bist #(.TRUTH(4'b0111), .SETTLE(2), .PASSES(3), .EW(2)) u_dut1 (
    .clk(clk), .nreset(nreset), .start(start_v[1]), .abort(abort_v[1]), .z(z1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fv1));

  oh_cell_bist #(.TRUTH(4'b0111), .SETTLE(1), .PASSES(1), .EW(8)) u_dut2 (
    .clk(clk), .nreset(nreset), .start(start_v[2]), .abort(abort_v[2]), .z(z2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_vec(fv2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t get_obs(input int d);
    obs_t o;
    case (d)
      0:       o = '{a0, b0, busy0, done0, pass0, err0, fv0};
      1:       o = '{a1, b1, busy1, done1, pass1, {6'b0, err1}, fv1};
      default: o = '{a2, b2, busy2, done2, pass2, err2, fv2};
    endcase
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int d);
    @(posedge clk); #1 start_v[d] = 1'b1;
    @(posedge clk); #1 start_v[d] = 1'b0;
  endtask

  task automatic watch_no_done(input int d, input int cycles, input string tag);
    int cnt = 0;
    obs_t o;
    repeat (cycles) begin
      @(posedge clk); #1;
      o = get_obs(d);
      if (o.done) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  task automatic wait_ab(input int d, input logic [1:0] ab);
    obs_t o;
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      o = get_obs(d);
      if ({o.a, o.b} == ab && o.busy) ok = 1;
    end
    if (!ok) check("wait_ab_timeout", 0, 1);
  endtask

  // One full run: push expectation, start, track vector sweep, pop on done.
  task automatic run(input int d, input int per, input int npass, input bit e_pass,
                     input int e_err, input logic [3:0] e_fv, input bit disturb);
    exp_t e;
    obs_t o;
    int n;
    bit got = 0;
    logic [7:0] seq = '0;
    exp_q.push_back('{4 * npass * per + 1, e_pass, e_err, e_fv});
    @(posedge clk); #1 start_v[d] = 1'b1;
    @(posedge clk); #1 start_v[d] = 1'b0;
    n = 1;
    o = get_obs(d);
    check("busy_on", o.busy, 1);
    seq = {seq[5:0], o.a, o.b};
    while (!got && n < 4 * npass * per + 40) begin
      @(posedge clk); #1;
      n++;
      start_v[d] = disturb && (n == 4 || n == 8);
      o = get_obs(d);
      if (o.done) got = 1;
      else if ((n - 1) % per == 0 && (n - 1) < 4 * per) seq = {seq[5:0], o.a, o.b};
    end
    start_v[d] = 1'b0;
    e = exp_q.pop_front();
    if (!got) begin
      check("done_timeout", 0, 1);
    end else begin
      check("latency", n, e.lat);
      check("pass", o.pass, e.pass);
      check("err_count", o.err, e.err);
      check("fail_vec", o.fv, e.fv);
      check("sweep", seq, 8'h1B);
      check("fin_busy", o.busy, 0);
      check("fin_ab", {o.a, o.b}, 0);
      if (disturb) begin
        start_v[d] = 1'b1;
        @(posedge clk); #1 start_v[d] = 1'b0;
        o = get_obs(d);
        check("fin_start_ignored", o.busy, 0);
        watch_no_done(d, 8, "single_done");
      end
    end
  endtask

  initial begin
    obs_t o;
    n_checks = 0;
    n_fail = 0;
    nreset = 1'b0;
    start_v = '0;
    abort_v = '0;
    mode0 = 0;
    mode1 = 2;
    mode2 = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check("reset_state", get_obs(d), 0);
    nreset = 1'b1;

    // Stuck-at-1 then ideal NAND on the default instance.
    mode0 = 1;
    run(0, 3 + PAD, 1, 0, 1, 4'b1000, 0);
    mode0 = 0;
    run(0, 3 + PAD, 1, 1, 0, 4'b0000, 0);

    // Stuck-at-0 across 3 passes with a 2-bit saturating counter.
    run(1, 3 + PAD, 3, 0, 3, 4'b0111, 0);

    // SETTLE=1 ideal NAND.
    run(2, 2 + PAD, 1, 1, 0, 4'b0000, 0);

    // Abort during vector 2 of an ideal run.
    pulse_start(0);
    wait_ab(0, 2'b10);
    abort_v[0] = 1'b1;
    @(posedge clk); #1 abort_v[0] = 1'b0;
    o = get_obs(0);
    check("abort_busy", o.busy, 0);
    check("abort_ab", {o.a, o.b}, 0);
    check("abort_pass", o.pass, 0);
    check("abort_done", o.done, 0);
    watch_no_done(0, 20, "abort_no_done");
    run(0, 3 + PAD, 1, 1, 0, 4'b0000, 0);

    // Start and abort together in IDLE: abort wins.
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    o = get_obs(0);
    check("start_abort_idle", o.busy, 0);
    check("start_abort_pass_kept", o.pass, 1);

    // Reset mid-run after a mismatch has been recorded.
    mode0 = 2;
    pulse_start(0);
    wait_ab(0, 2'b01);
    o = get_obs(0);
    check("pre_reset_err", o.err, 1);
    check("pre_reset_fv", o.fv, 4'b0001);
    nreset = 1'b0;
    #1;
    check("async_reset", get_obs(0), 0);
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    watch_no_done(0, 6, "reset_no_done");
    o = get_obs(0);
    check("reset_idle_busy", o.busy, 0);
    mode0 = 0;
    run(0, 3 + PAD, 1, 1, 0, 4'b0000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oh_cell_bist.md
OH_CELL_BIST -- requirements
Module: oh_cell_bist

Interface
REQ-001 Parameter TRUTH, default 4'b0111, expected z per input vector; bit index = {a,b}, so the default encodes a 2-input NAND.
REQ-002 Parameter SETTLE, default 2, cycles each vector is held before compare; legal range 1..255.
REQ-003 Parameter PASSES, default 1, full 4-vector sweeps per run; legal range 1..255.
REQ-004 Parameter EW, default 8, width of err_count.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 nreset  input  1  asynchronous active-low reset.
REQ-007 start  input  1  run request, sampled in IDLE only.
REQ-008 abort  input  1  synchronous run cancel.
REQ-009 z  input  1  output of cell under test.
REQ-010 a  output  1  drives cell input a, registered.
REQ-011 b  output  1  drives cell input b, registered.
REQ-012 busy  output  1  high while a run is in progress.
REQ-013 done  output  1  one-cycle pulse at run completion.
REQ-014 pass  output  1  high when the last completed run had zero mismatches.
REQ-015 err_count  output  EW  mismatch count of current/last run.
REQ-016 fail_vec  output  4  sticky per-vector mismatch flags, bit index = {a,b}.

Function
REQ-017 FSM states: IDLE, HOLD, CMP, FIN; state changes only on clk rising edge.
REQ-018 IDLE with start=1: next cycle enter HOLD, vector=0, pass count=0, busy=1, err_count=0, fail_vec=0, pass=0.
REQ-019 {a,b} shall equal the current vector index registered, changing in the same cycle HOLD is entered for that vector.
REQ-020 HOLD lasts SETTLE cycles (SETTLE-1 wait + transition), then CMP for one cycle; per-vector time = SETTLE+1 cycles.
REQ-021 In CMP, sample compared against TRUTH[vector]; on mismatch err_count increments and fail_vec[vector] sets.
REQ-022 err_count saturates at 2^EW-1; fail_vec bits stay set until next accepted start or reset.
REQ-023 After CMP: vector<3 -> vector+1, HOLD; vector==3 and pass count<PASSES-1 -> vector wraps to 0, pass count+1, HOLD; else FIN.
REQ-024 FIN lasts one cycle: done=1, busy=0 next cycle, pass=(err_count==0 including the final CMP), a=b=0; then IDLE.
REQ-025 Total run latency, start accepted to done pulse = 4*PASSES*(SETTLE+1)+1 cycles.
REQ-026 start while busy is ignored; start in the FIN cycle is ignored.
REQ-027 abort=1 in HOLD or CMP: next state IDLE, busy=0, a=b=0, done not pulsed, pass=0, err_count and fail_vec keep values; abort has priority over CMP update of the same cycle.
REQ-028 abort in IDLE or FIN has no effect; start and abort together in IDLE: abort wins, run not started.

Reset
REQ-029 nreset low asynchronously forces IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, counters=0.
REQ-030 Reset asserted mid-run discards the run; no done pulse on release; first start after release begins a clean run.

Configuration
REQ-031 Macro OH_CELL_BIST_SYNC_EN defined: z passes through a two-flop synchronizer (reset to 0) before compare, and HOLD is extended by 2 cycles, so per-vector time = SETTLE+3 and latency = 4*PASSES*(SETTLE+3)+1.
REQ-032 Macro undefined: z compared directly in CMP, no synchronizer flops, timing per REQ-020 and REQ-025.

Verification
REQ-033 Ideal NAND model on a/b->z, defaults, start pulse -> a/b sweep 00,01,10,11, done at cycle 13, pass=1, err_count=0, fail_vec=0.
REQ-034 z stuck at 1, defaults -> done, pass=0, err_count=1, fail_vec=4'b1000.
REQ-035 z stuck at 0, PASSES=3, EW=2 -> err_count saturates at 3, fail_vec=4'b0111, pass=0, done at cycle 37.
REQ-036 abort during vector 2 of an ideal-NAND run -> busy low next cycle, a=b=0, no done, pass=0; following start completes with pass=1.
REQ-037 nreset low during HOLD, then start pulses while busy -> outputs all zero on reset; mid-run starts ignored, single done per run.
REQ-038 OH_CELL_BIST_SYNC_EN defined, ideal NAND, SETTLE=1 -> done at cycle 17, pass=1.
